dla_axi4_copy_ctrl: RTL and testbench
=====================================

DLA_AXI4_COPY_CTRL -- requirements
Module: dla_axi4_copy_ctrl

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width of all address ports.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, width of one data word.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the word-count ports.
REQ-004 SHALL have port clk_i  input  1  clock; all logic is rising-edge.
REQ-005 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  start a copy; sampled only in IDLE.
REQ-007 SHALL have port abort_i  input  1  stop after the in-flight word completes.
REQ-008 SHALL have port src_addr_i  input  AXI_ADDR_WIDTH  source base byte address; latched on start.
REQ-009 SHALL have port dst_addr_i  input  AXI_ADDR_WIDTH  destination base byte address; latched on start.
REQ-010 SHALL have port len_i  input  LEN_WIDTH  number of words to copy; latched on start.
REQ-011 SHALL have port busy_o  output  1  high from the cycle after accepted start until DONE exits.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse when a copy ends.
REQ-013 SHALL have port aborted_o  output  1  copy ended by abort; valid with done_o, held until next start.
REQ-014 SHALL have port words_done_o  output  LEN_WIDTH  count of completed word writes.
REQ-015 SHALL have port req_o  output  2  request to the AXI4 manager; bit 1 read, bit 0 write.
REQ-016 SHALL have port rd_addr_o  output  AXI_ADDR_WIDTH  current read byte address.
REQ-017 SHALL have port wr_addr_o  output  AXI_ADDR_WIDTH  current write byte address.
REQ-018 SHALL have port wr_data_o  output  AXI_DATA_WIDTH  word to write; stable while req_o[0] high.
REQ-019 SHALL have port rsp_i  input  2  manager completion pulses; bit 1 read, bit 0 write.
REQ-020 SHALL have port rd_data_i  input  AXI_DATA_WIDTH  manager read data; valid the cycle after rsp_i[1].

Function
REQ-021 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, RD_CAP, WR_REQ, WR_WAIT, DONE.
REQ-022 IDLE: start_i=1 with len_i!=0 -> latch src/dst/len, clear words_done_o and aborted_o, go RD_REQ.
REQ-023 IDLE: start_i=1 with len_i=0 -> go DONE directly, no manager request, aborted_o=0.
REQ-024 RD_REQ: drive req_o[1]=1 for exactly this one cycle, then go RD_WAIT.
REQ-025 RD_WAIT: on rsp_i[1]=1 go RD_CAP; otherwise wait indefinitely.
REQ-026 RD_CAP: register rd_data_i into the word buffer (wr_data_o), go WR_REQ.
REQ-027 WR_REQ: drive req_o[0]=1 for exactly this one cycle, then go WR_WAIT.
REQ-028 WR_WAIT: on rsp_i[0]=1, increment words_done_o and advance both addresses by AXI_DATA_WIDTH/8.
REQ-029 WR_WAIT exit: go DONE if words_done_o+1 equals latched length or abort is pending, else go RD_REQ.
REQ-030 DONE: assert done_o for one cycle, go IDLE; start_i is ignored in DONE.
REQ-031 req_o SHALL never have both bits set and SHALL be zero outside RD_REQ/WR_REQ.
REQ-032 A new request SHALL be issued no earlier than one cycle after the preceding rsp_i pulse.
REQ-033 abort_i=1 in any non-IDLE state SHALL set a sticky abort-pending flag.
REQ-034 Abort does not cancel an issued request; its response is still awaited.
REQ-035 An abort seen in RD_REQ/RD_WAIT/RD_CAP still completes that word's write before DONE.
REQ-036 An abort ending a copy SHALL set aborted_o=1, even if the last word was also just written.
REQ-037 Address increments SHALL wrap modulo 2^AXI_ADDR_WIDTH without error.
REQ-038 rsp_i bits arriving in a state other than the matching WAIT state SHALL be ignored.
REQ-039 start_i while busy_o=1 SHALL be ignored without side effects.

Reset
REQ-040 On rstn_i=0, state SHALL be IDLE, all outputs 0, and the latched registers and abort flag cleared.
REQ-041 Reset mid-copy SHALL abandon the copy without a done_o pulse.
REQ-042 After reset, the copy controller SHALL rely on the manager being reset by the same rstn_i.

Structure
REQ-043 The FSM state enum SHALL be defined in shared package dla_axi_pkg, with a LEN_WIDTH default constant.
REQ-044 The block SHALL be a single module with no sub-modules.
REQ-045 The block SHALL connect directly to the AXI4 manager's req/addr/data/rsp ports.

Verification
REQ-046 Bench: src=0x1000, dst=0x2000, len=3, manager + AXI memory model -> three words copied to 0x2000/08/10, done_o once, words_done_o=3, aborted_o=0.
REQ-047 Bench: len=0 -> done_o pulses two cycles after start, req_o stays 0, words_done_o=0.
REQ-048 Bench: len=8, abort_i pulsed while word 2 is in RD_WAIT -> word 2 written, done_o, words_done_o=3, aborted_o=1.
REQ-049 Bench: src=0xFFFFFFF8, len=2 -> second read address is 0x00000000.
REQ-050 Bench: start_i held high through a len=2 copy -> exactly one copy, second start accepted only after returning to IDLE.
REQ-051 Bench: rstn_i low in WR_WAIT -> all outputs 0 next cycle, no done_o, new len=1 copy then succeeds.

Source files
------------

// File: rtl/dla_axi_pkg.sv
// Shared AXI helper package: copy-controller FSM encoding and default widths.
package dla_axi_pkg;

   localparam int LEN_WIDTH_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_RD_CAP,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_DONE
   } copy_state_e;

endpackage

// File: rtl/dla_axi4_copy_ctrl.sv
// Word-at-a-time memory copy sequencer driving an AXI4 manager's simple
// req/rsp handshake: read one word, write it back out, repeat.
module dla_axi4_copy_ctrl
   import dla_axi_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int LEN_WIDTH      = LEN_WIDTH_DEFAULT
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [AXI_ADDR_WIDTH-1:0] src_addr_i,
   input  logic [AXI_ADDR_WIDTH-1:0] dst_addr_i,
   input  logic [LEN_WIDTH-1:0]      len_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      aborted_o,
   output logic [LEN_WIDTH-1:0]      words_done_o,
   output logic [1:0]                req_o,
   output logic [AXI_ADDR_WIDTH-1:0] rd_addr_o,
   output logic [AXI_ADDR_WIDTH-1:0] wr_addr_o,
   output logic [AXI_DATA_WIDTH-1:0] wr_data_o,
   input  logic [1:0]                rsp_i,
   input  logic [AXI_DATA_WIDTH-1:0] rd_data_i
);

   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);

   copy_state_e               state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
   logic [AXI_DATA_WIDTH-1:0] data_q;
   logic [LEN_WIDTH-1:0]      len_q, words_q;
   logic                      abort_pend_q, aborted_q, done_q;

   logic start_ok, last_word, abort_now, wr_rsp;

   assign start_ok  = (state_q == ST_IDLE) && start_i;
   assign last_word = (words_q + LEN_WIDTH'(1)) == len_q;
   // An abort arriving in the same cycle as the write response still ends the copy.
   assign abort_now = abort_pend_q | abort_i;
   assign wr_rsp    = (state_q == ST_WR_WAIT) && rsp_i[0];

   always_comb begin
      state_d = state_q;
      req_o   = 2'b00;
      case (state_q)
         ST_IDLE:    if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_RD_REQ;
         ST_RD_REQ:  begin
            req_o   = 2'b10;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: if (rsp_i[1]) state_d = ST_RD_CAP;
         ST_RD_CAP:  state_d = ST_WR_REQ;
         ST_WR_REQ:  begin
            req_o   = 2'b01;
            state_d = ST_WR_WAIT;
         end
         ST_WR_WAIT: if (rsp_i[0]) state_d = (last_word || abort_now) ? ST_DONE : ST_RD_REQ;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_addr_q    <= '0;
         wr_addr_q    <= '0;
         data_q       <= '0;
         len_q        <= '0;
         words_q      <= '0;
         abort_pend_q <= 1'b0;
         aborted_q    <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= (state_q == ST_DONE);
         if (start_ok) begin
            rd_addr_q    <= src_addr_i;
            wr_addr_q    <= dst_addr_i;
            len_q        <= len_i;
            words_q      <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
         end else if (state_q != ST_IDLE && abort_i) begin
            abort_pend_q <= 1'b1;
         end
         if (state_q == ST_RD_CAP) data_q <= rd_data_i;
         // Address arithmetic wraps naturally at the register width.
         if (wr_rsp) begin
            words_q   <= words_q + LEN_WIDTH'(1);
            rd_addr_q <= rd_addr_q + ADDR_STEP;
            wr_addr_q <= wr_addr_q + ADDR_STEP;
            if (abort_now) aborted_q <= 1'b1;
         end
      end
   end

   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = done_q;
   assign aborted_o    = aborted_q;
   assign words_done_o = words_q;
   assign rd_addr_o    = rd_addr_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = data_q;

endmodule

// File: tb/tb_dla_axi4_copy_ctrl.sv
// Directed bench for dla_axi4_copy_ctrl with a small manager/memory model.
module tb_dla_axi4_copy_ctrl;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int LW = 16;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [AW-1:0] src_addr_i = '0;
   logic [AW-1:0] dst_addr_i = '0;
   logic [LW-1:0] len_i = '0;
   logic          busy_o, done_o, aborted_o;
   logic [LW-1:0] words_done_o;
   logic [1:0]    req_o;
   logic [AW-1:0] rd_addr_o, wr_addr_o;
   logic [DW-1:0] wr_data_o;
   logic [1:0]    rsp_i = 2'b00;
   logic [DW-1:0] rd_data_i = '0;

   dla_axi4_copy_ctrl #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .words_done_o(words_done_o),
      .req_o(req_o), .rd_addr_o(rd_addr_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .rsp_i(rsp_i), .rd_data_i(rd_data_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] wmem [logic [AW-1:0]];
   logic [AW-1:0] rd_addrs [$];
   int            done_cnt = 0, rd_reqs = 0, wr_reqs = 0, both_cnt = 0;
   int            rd_lat = 0, wr_lat = 0;
   bit            rd_data_pend = 1'b0;
   logic [AW-1:0] rd_a = '0, wr_a = '0;
   logic [DW-1:0] wr_d = '0;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {a ^ 32'hDEAD_BEEF, ~a};
   endfunction

   // Manager model: 2-cycle response latency, read data one cycle after rsp.
   initial begin
      forever begin
         @(negedge clk_i);
         rsp_i = 2'b00;
         if (!rstn_i) begin
            rd_lat = 0;
            wr_lat = 0;
            rd_data_pend = 1'b0;
            rd_data_i = '0;
         end else begin
            if (rd_data_pend) begin
               rd_data_i = pat(rd_a);
               rd_data_pend = 1'b0;
            end
            if (rd_lat > 0) begin
               rd_lat--;
               if (rd_lat == 0) begin
                  rsp_i[1] = 1'b1;
                  rd_data_pend = 1'b1;
               end
            end
            if (wr_lat > 0) begin
               wr_lat--;
               if (wr_lat == 0) begin
                  wmem[wr_a] = wr_d;
                  rsp_i[0] = 1'b1;
               end
            end
            if (req_o == 2'b11) both_cnt++;
            if (req_o[1]) begin
               rd_a = rd_addr_o;
               rd_lat = 2;
               rd_reqs++;
               rd_addrs.push_back(rd_addr_o);
            end
            if (req_o[0]) begin
               wr_a = wr_addr_o;
               wr_d = wr_data_o;
               wr_lat = 2;
               wr_reqs++;
            end
         end
         if (done_o) done_cnt++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_counts();
      done_cnt = 0;
      rd_reqs = 0;
      wr_reqs = 0;
      both_cnt = 0;
      rd_addrs.delete();
      wmem.delete();
   endtask

   task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
      @(posedge clk_i);
      #1;
      src_addr_i = s;
      dst_addr_i = d;
      len_i = l;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_i);
         if (done_o) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({busy_o, done_o, aborted_o, req_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 00000", {busy_o, done_o, aborted_o, req_o});
      end
      checks++;
      if (words_done_o !== '0) begin
         errors++;
         $display("FAIL reset_words: got %0d want 0", words_done_o);
      end
      checks++;
      if ({rd_addr_o, wr_addr_o, wr_data_o} !== '0) begin
         errors++;
         $display("FAIL reset_addr_data: got %h %h %h want 0", rd_addr_o, wr_addr_o, wr_data_o);
      end
      @(negedge clk_i);
      rstn_i = 1'b1;
   endtask

   task automatic test_basic_copy();
      bit ok;
      clear_counts();
      do_start(32'h1000, 32'h2000, 16'd3);
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b want 1", busy_o);
      end
      wait_done(300, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_done_timeout: got no done want done");
      end
      checks++;
      if (words_done_o !== 16'd3 || aborted_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_status: got words=%0d aborted=%b want words=3 aborted=0", words_done_o, aborted_o);
      end
      repeat (3) @(negedge clk_i);
      checks++;
      if (done_cnt != 1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_count: got %0d busy=%b want 1 busy=0", done_cnt, busy_o);
      end
      for (int i = 0; i < 3; i++) begin
         logic [AW-1:0] da, sa;
         da = 32'h2000 + 32'(i * 8);
         sa = 32'h1000 + 32'(i * 8);
         checks++;
         if (!wmem.exists(da) || wmem[da] !== pat(sa)) begin
            errors++;
            $display("FAIL basic_mem[%h]: got %h want %h", da, wmem.exists(da) ? wmem[da] : 'x, pat(sa));
         end
      end
      checks++;
      if (both_cnt != 0 || rd_reqs != 3 || wr_reqs != 3) begin
         errors++;
         $display("FAIL basic_reqs: got both=%0d rd=%0d wr=%0d want 0 3 3", both_cnt, rd_reqs, wr_reqs);
      end
   endtask

   task automatic test_len_zero();
      clear_counts();
      do_start(32'h1000, 32'h2000, 16'd0);
      checks++;
      if (busy_o !== 1'b1 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL len0_first: got busy=%b done=%b want 1 0", busy_o, done_o);
      end
      @(posedge clk_i);
      #1;
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL len0_done: got done=%b busy=%b want 1 0", done_o, busy_o);
      end
      checks++;
      if (words_done_o !== '0 || aborted_o !== 1'b0) begin
         errors++;
         $display("FAIL len0_status: got words=%0d aborted=%b want 0 0", words_done_o, aborted_o);
      end
      @(posedge clk_i);
      #1;
      checks++;
      if (done_o !== 1'b0) begin
         errors++;
         $display("FAIL len0_pulse: got done=%b want 0", done_o);
      end
      checks++;
      if (rd_reqs != 0 || wr_reqs != 0) begin
         errors++;
         $display("FAIL len0_reqs: got rd=%0d wr=%0d want 0 0", rd_reqs, wr_reqs);
      end
   endtask

   task automatic test_abort();
      bit ok;
      bit seen;
      clear_counts();
      do_start(32'h4000, 32'h5000, 16'd8);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk_i);
         if (req_o[1] && words_done_o == 16'd2) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL abort_word2_read: got no read for word 2 want one");
      end
      @(posedge clk_i);
      #1 abort_i = 1'b1;
      @(posedge clk_i);
      #1 abort_i = 1'b0;
      wait_done(300, ok);
      checks++;
      if (!ok || words_done_o !== 16'd3 || aborted_o !== 1'b1) begin
         errors++;
         $display("FAIL abort_status: got done=%b words=%0d aborted=%b want 1 3 1", ok, words_done_o, aborted_o);
      end
      repeat (3) @(negedge clk_i);
      checks++;
      if (wr_reqs != 3 || rd_reqs != 3 || done_cnt != 1) begin
         errors++;
         $display("FAIL abort_reqs: got rd=%0d wr=%0d done=%0d want 3 3 1", rd_reqs, wr_reqs, done_cnt);
      end
      checks++;
      if (!wmem.exists(32'h5010) || wmem[32'h5010] !== pat(32'h4010)) begin
         errors++;
         $display("FAIL abort_word2_mem: got %h want %h", wmem.exists(32'h5010) ? wmem[32'h5010] : 'x, pat(32'h4010));
      end
   endtask

   task automatic test_wrap();
      bit ok;
      clear_counts();
      do_start(32'hFFFF_FFF8, 32'h0000_0100, 16'd2);
      wait_done(300, ok);
      repeat (2) @(negedge clk_i);
      checks++;
      if (!ok || rd_addrs.size() != 2) begin
         errors++;
         $display("FAIL wrap_reads: got done=%b reads=%0d want 1 2", ok, rd_addrs.size());
      end else begin
         checks++;
         if (rd_addrs[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got %h want 00000000", rd_addrs[1]);
         end
      end
      checks++;
      if (!wmem.exists(32'h108) || wmem[32'h108] !== pat(32'h0) || aborted_o !== 1'b0) begin
         errors++;
         $display("FAIL wrap_mem: got %h aborted=%b want %h aborted=0", wmem.exists(32'h108) ? wmem[32'h108] : 'x, aborted_o, pat(32'h0));
      end
   endtask

   task automatic test_start_held();
      bit ok;
      clear_counts();
      @(posedge clk_i);
      #1;
      src_addr_i = 32'h3000;
      dst_addr_i = 32'h6000;
      len_i = 16'd2;
      start_i = 1'b1;
      wait_done(300, ok);
      checks++;
      if (!ok || rd_reqs != 2 || wr_reqs != 2) begin
         errors++;
         $display("FAIL held_first: got done=%b rd=%0d wr=%0d want 1 2 2", ok, rd_reqs, wr_reqs);
      end
      @(posedge clk_i);
      #1 start_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL held_restart: got busy=%b want 1", busy_o);
      end
      wait_done(300, ok);
      repeat (3) @(negedge clk_i);
      checks++;
      if (!ok || words_done_o !== 16'd2 || wr_reqs != 4 || done_cnt != 2) begin
         errors++;
         $display("FAIL held_second: got done=%b words=%0d wr=%0d dones=%0d want 1 2 4 2", ok, words_done_o, wr_reqs, done_cnt);
      end
   endtask

   task automatic test_reset_midcopy();
      bit ok;
      bit seen;
      clear_counts();
      do_start(32'h7000, 32'h8000, 16'd4);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk_i);
         if (req_o[0] && words_done_o == 16'd1) seen = 1'b1;
      end
      @(posedge clk_i);
      #1 rstn_i = 1'b0;
      #1;
      checks++;
      if (!seen || {busy_o, done_o, aborted_o, req_o} !== 5'b0 || words_done_o !== '0) begin
         errors++;
         $display("FAIL rst_mid_ctrl: got seen=%b ctrl=%b words=%0d want 1 00000 0", seen, {busy_o, done_o, aborted_o, req_o}, words_done_o);
      end
      checks++;
      if ({rd_addr_o, wr_addr_o, wr_data_o} !== '0) begin
         errors++;
         $display("FAIL rst_mid_addr: got %h %h %h want 0", rd_addr_o, wr_addr_o, wr_data_o);
      end
      repeat (3) @(negedge clk_i);
      rstn_i = 1'b1;
      repeat (2) @(negedge clk_i);
      checks++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL rst_mid_nodone: got %0d want 0", done_cnt);
      end
      clear_counts();
      do_start(32'h9000, 32'hA000, 16'd1);
      wait_done(300, ok);
      checks++;
      if (!ok || words_done_o !== 16'd1 || aborted_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_recopy: got done=%b words=%0d aborted=%b want 1 1 0", ok, words_done_o, aborted_o);
      end
      checks++;
      if (!wmem.exists(32'hA000) || wmem[32'hA000] !== pat(32'h9000)) begin
         errors++;
         $display("FAIL rst_mid_mem: got %h want %h", wmem.exists(32'hA000) ? wmem[32'hA000] : 'x, pat(32'h9000));
      end
   endtask

   initial begin
      test_reset();
      test_basic_copy();
      test_len_zero();
      test_abort();
      test_wrap();
      test_start_held();
      test_reset_midcopy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
